bus_term_fifo: RTL and testbench
================================

BUS_TERM_FIFO -- requirements
Module: bus_term_fifo

Interface
REQ-001 SHALL have parameter PCKG_SZ, default 16, packet width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entries per FIFO; power of two, >=2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  host writes wr_data into TX FIFO.
REQ-006 SHALL have port wr_data  input  PCKG_SZ  host TX packet.
REQ-007 SHALL have port tx_full  output  1  TX FIFO holds DEPTH entries.
REQ-008 SHALL have port pndng  output  1  TX FIFO non-empty, presented to bus.
REQ-009 SHALL have port D_pop  output  PCKG_SZ  TX head packet, presented to bus.
REQ-010 SHALL have port pop  input  1  bus consumes TX head.
REQ-011 SHALL have port push  input  1  bus delivers D_push into RX FIFO.
REQ-012 SHALL have port D_push  input  PCKG_SZ  bus RX packet.
REQ-013 SHALL have port rd_en  input  1  host reads RX head.
REQ-014 SHALL have port rd_data / rd_valid  output  PCKG_SZ / 1  registered RX read result.
REQ-015 SHALL have ports tx_count, rx_count  output  $clog2(DEPTH+1)  occupancy.
REQ-016 SHALL have ports tx_ovf, rx_ovf, tx_unf  output  1  sticky error flags.

Function
REQ-017 TX SHALL be show-ahead: D_pop = head entry when pndng=1, all-zero when empty; pndng = (tx_count != 0), driven from registered count.
REQ-018 wr_en with TX not full SHALL store wr_data, visible on D_pop next cycle if FIFO was empty.
REQ-019 wr_en with TX full and pop=0 SHALL drop data and set tx_ovf; with pop=1, write SHALL be accepted, count unchanged.
REQ-020 pop with TX empty SHALL be ignored and set tx_unf; a simultaneous wr_en SHALL still be accepted.
REQ-021 push with RX not full SHALL store D_push; at full with rd_en=0 SHALL drop and set rx_ovf; at full with rd_en=1 both SHALL be accepted.
REQ-022 rd_en with RX non-empty SHALL load head into rd_data and pulse rd_valid the next cycle (latency 1); rd_en when empty SHALL leave rd_data unchanged, rd_valid=0.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; counts SHALL never exceed DEPTH or underflow.
REQ-024 Order SHALL be strictly FIFO per direction; TX and RX paths independent.
REQ-025 Sticky flags SHALL clear only on reset.

Reset
REQ-026 reset SHALL clear pointers and counts, pndng=0, D_pop=0, tx_full=0, rd_data=0, rd_valid=0, all flags=0.
REQ-027 reset SHALL dominate any same-cycle wr_en/pop/push/rd_en; mid-operation contents SHALL be discarded.

Configuration
REQ-028 Macro BUS_TERM_FIFO_STATS_EN defined: SHALL add outputs tx_sent_cnt, rx_recv_cnt (16 bit, saturating at 0xFFFF), incremented per accepted pop / accepted push, cleared on reset.
REQ-029 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package bus_term_pkg SHALL hold default PCKG_SZ/DEPTH constants and count/pointer width helper typedefs.
REQ-031 One sub-module sync_fifo (parameterised width/depth, count, full/empty) SHALL be instantiated twice, TX and RX.

Verification
REQ-032 Reset, write 0xA001, 0xA002 -> pndng=1, D_pop=0xA001; pop -> D_pop=0xA002; pop -> pndng=0, D_pop=0.
REQ-033 Write 9 packets with DEPTH=8, no pop -> tx_count=8, tx_full=1, tx_ovf=1, 9th lost; pops return 1..8 in order.
REQ-034 TX full, wr_en=1 and pop=1 same cycle -> tx_count stays 8, tx_ovf stays 0, new packet last out.
REQ-035 pop on empty TX with wr_en=1, wr_data=0x5555 -> tx_unf=1, tx_count=1, D_pop=0x5555.
REQ-036 push 0x1234 then rd_en -> rd_valid=1 with rd_data=0x1234 one cycle after rd_en; push 9 times -> rx_ovf=1.
REQ-037 Fill both FIFOs, assert reset for one cycle with push/wr_en high -> all counts 0, flags 0, pndng=0.

Source files
------------

// File: rtl/bus_term_pkg.sv
// bus_term_pkg: shared defaults, width helpers and counter types for the bus terminal FIFO.
package bus_term_pkg;
  localparam int PCKG_SZ_DEF = 16;
  localparam int DEPTH_DEF = 8;
  localparam int STAT_W = 16;
  typedef logic [STAT_W-1:0] stat_t;
  typedef logic [$clog2(DEPTH_DEF+1)-1:0] cnt_t;
  typedef logic [$clog2(DEPTH_DEF)-1:0] ptr_t;
  function automatic int cnt_w(int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_w(int depth);
    return $clog2(depth);
  endfunction
  function automatic stat_t sat_inc(stat_t v);
    return v == '1 ? v : v + stat_t'(1);
  endfunction
endpackage

// File: rtl/bus_term_fifo_if.sv
// bus_term_fifo_if: host and bus signals of the terminal FIFO; BUS_TERM_FIFO_STATS_EN adds traffic counters.
interface bus_term_fifo_if
  import bus_term_pkg::*;
#(
  parameter int PCKG_SZ = PCKG_SZ_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  logic wr_en;
  logic [PCKG_SZ-1:0] wr_data;
  logic tx_full;
  logic pndng;
  logic [PCKG_SZ-1:0] D_pop;
  logic pop;
  logic push;
  logic [PCKG_SZ-1:0] D_push;
  logic rd_en;
  logic [PCKG_SZ-1:0] rd_data;
  logic rd_valid;
  logic [cnt_w(DEPTH)-1:0] tx_count;
  logic [cnt_w(DEPTH)-1:0] rx_count;
  logic tx_ovf;
  logic rx_ovf;
  logic tx_unf;
`ifdef BUS_TERM_FIFO_STATS_EN
  stat_t tx_sent_cnt;
  stat_t rx_recv_cnt;
`endif
  modport slave (
    input wr_en, wr_data, pop, push, D_push, rd_en,
    output tx_full, pndng, D_pop, rd_data, rd_valid, tx_count, rx_count, tx_ovf, rx_ovf, tx_unf
`ifdef BUS_TERM_FIFO_STATS_EN
    , output tx_sent_cnt, rx_recv_cnt
`endif
  );
  modport master (
    output wr_en, wr_data, pop, push, D_push, rd_en,
    input tx_full, pndng, D_pop, rd_data, rd_valid, tx_count, rx_count, tx_ovf, rx_ovf, tx_unf
`ifdef BUS_TERM_FIFO_STATS_EN
    , input tx_sent_cnt, rx_recv_cnt
`endif
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; a write at full is taken only when a read frees a slot that cycle.
module sync_fifo
  import bus_term_pkg::*;
#(
  parameter int W = PCKG_SZ_DEF,
  parameter int D = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [W-1:0]          din,
  input  logic                  rd,
  output logic [W-1:0]          dout,
  output logic [cnt_w(D)-1:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int CW = cnt_w(D);
  localparam int PW = ptr_w(D);
  logic [W-1:0] mem [D];
  logic [PW-1:0] wp, rp;
  logic do_wr, do_rd;
  always_comb begin
    empty = count == '0;
    full = count == CW'(D);
    do_rd = rd && !empty;
    do_wr = wr && (!full || do_rd);
    dout = empty ? '0 : mem[rp];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + PW'(1);
      if (do_rd) rp <= rp + PW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end
  always_ff @(posedge clk)
    if (do_wr && !reset) mem[wp] <= din;
endmodule

// File: rtl/bus_term_fifo.sv
// bus_term_fifo: host<->bus packet terminal with independent TX/RX FIFOs and sticky error flags.
// Define BUS_TERM_FIFO_STATS_EN to add saturating sent/received packet counters.
module bus_term_fifo
  import bus_term_pkg::*;
#(
  parameter int PCKG_SZ = PCKG_SZ_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic reset,
  bus_term_fifo_if.slave bus
);
  logic tx_empty, rx_full, rx_empty;
  logic [PCKG_SZ-1:0] rx_head;
  sync_fifo #(.W(PCKG_SZ), .D(DEPTH)) u_tx (
    .clk(clk), .reset(reset), .wr(bus.wr_en), .din(bus.wr_data), .rd(bus.pop),
    .dout(bus.D_pop), .count(bus.tx_count), .full(bus.tx_full), .empty(tx_empty)
  );
  sync_fifo #(.W(PCKG_SZ), .D(DEPTH)) u_rx (
    .clk(clk), .reset(reset), .wr(bus.push), .din(bus.D_push), .rd(bus.rd_en),
    .dout(rx_head), .count(bus.rx_count), .full(rx_full), .empty(rx_empty)
  );
  assign bus.pndng = !tx_empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_data <= '0;
      bus.rd_valid <= 1'b0;
      bus.tx_ovf <= 1'b0;
      bus.rx_ovf <= 1'b0;
      bus.tx_unf <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en && !rx_empty;
      if (bus.rd_en && !rx_empty) bus.rd_data <= rx_head;
      if (bus.wr_en && bus.tx_full && !bus.pop) bus.tx_ovf <= 1'b1;
      if (bus.pop && tx_empty) bus.tx_unf <= 1'b1;
      if (bus.push && rx_full && !bus.rd_en) bus.rx_ovf <= 1'b1;
    end
  end
`ifdef BUS_TERM_FIFO_STATS_EN
  // a full RX is never empty, so rd_en there always frees the slot the push needs
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.tx_sent_cnt <= '0;
      bus.rx_recv_cnt <= '0;
    end else begin
      if (bus.pop && !tx_empty) bus.tx_sent_cnt <= sat_inc(bus.tx_sent_cnt);
      if (bus.push && (!rx_full || bus.rd_en)) bus.rx_recv_cnt <= sat_inc(bus.rx_recv_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_bus_term_fifo.sv
// tb_bus_term_fifo: directed and random stimulus against a queue-based reference model with a decoupled scoreboard.
module tb_bus_term_fifo;
  import bus_term_pkg::*;
  localparam int W = 16;
  localparam int D = 8;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  bus_term_fifo_if #(.PCKG_SZ(W), .DEPTH(D)) bus ();
  bus_term_fifo #(.PCKG_SZ(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic pndng, full, tovf, rovf, tunf, rv;
    logic [W-1:0] dpop, rdat;
    int tc, rc, ts, rr;
  } snap_t;
  snap_t exp_q[$];
  snap_t s;
  logic [W-1:0] tq[$];
  logic [W-1:0] rq[$];
  logic m_tovf, m_rovf, m_tunf, m_rv;
  logic [W-1:0] m_rdat;
  int m_ts, m_rr;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_step();
    snap_t n;
    bit tp, tw, rd, rw;
    if (reset) begin
      tq.delete();
      rq.delete();
      {m_tovf, m_rovf, m_tunf, m_rv} = '0;
      m_rdat = '0;
      m_ts = 0;
      m_rr = 0;
    end else begin
      tp = bus.pop && tq.size() > 0;
      tw = bus.wr_en && (tq.size() < D || tp);
      if (bus.pop && tq.size() == 0) m_tunf = 1'b1;
      if (bus.wr_en && !tw) m_tovf = 1'b1;
      if (tp) begin
        void'(tq.pop_front());
        if (m_ts < 65535) m_ts++;
      end
      if (tw) tq.push_back(bus.wr_data);
      rd = bus.rd_en && rq.size() > 0;
      rw = bus.push && (rq.size() < D || rd);
      if (bus.push && !rw) m_rovf = 1'b1;
      m_rv = rd;
      if (rd) m_rdat = rq.pop_front();
      if (rw) begin
        rq.push_back(bus.D_push);
        if (m_rr < 65535) m_rr++;
      end
    end
    n.pndng = tq.size() > 0;
    n.dpop = tq.size() > 0 ? tq[0] : '0;
    n.full = tq.size() == D;
    n.tc = tq.size();
    n.rc = rq.size();
    n.tovf = m_tovf;
    n.rovf = m_rovf;
    n.tunf = m_tunf;
    n.rv = m_rv;
    n.rdat = m_rdat;
    n.ts = m_ts;
    n.rr = m_rr;
    exp_q.push_back(n);
  endtask

  task automatic step(input logic w, input logic [W-1:0] wd, input logic p, input logic pu,
                      input logic [W-1:0] dp, input logic r, input logic rs);
    @(negedge clk);
    bus.wr_en = w;
    bus.wr_data = wd;
    bus.pop = p;
    bus.push = pu;
    bus.D_push = dp;
    bus.rd_en = r;
    reset = rs;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, '0, 0, 0, '0, 0, 1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      chk("pndng", bus.pndng, s.pndng);
      chk("D_pop", bus.D_pop, s.dpop);
      chk("tx_full", bus.tx_full, s.full);
      chk("tx_count", bus.tx_count, s.tc);
      chk("rx_count", bus.rx_count, s.rc);
      chk("tx_ovf", bus.tx_ovf, s.tovf);
      chk("rx_ovf", bus.rx_ovf, s.rovf);
      chk("tx_unf", bus.tx_unf, s.tunf);
      chk("rd_valid", bus.rd_valid, s.rv);
      chk("rd_data", bus.rd_data, s.rdat);
`ifdef BUS_TERM_FIFO_STATS_EN
      chk("tx_sent_cnt", bus.tx_sent_cnt, s.ts);
      chk("rx_recv_cnt", bus.rx_recv_cnt, s.rr);
`endif
    end
  end

  initial begin
    reset = 1'b1;
    {bus.wr_en, bus.pop, bus.push, bus.rd_en} = '0;
    bus.wr_data = '0;
    bus.D_push = '0;
    do_reset();
    do_reset();
    step(1, 16'hA001, 0, 0, '0, 0, 0);
    step(1, 16'hA002, 0, 0, '0, 0, 0);
    idle();
    step(0, '0, 1, 0, '0, 0, 0);
    step(0, '0, 1, 0, '0, 0, 0);
    idle();
    for (int i = 1; i <= 9; i++) step(1, W'(i), 0, 0, '0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, '0, 1, 0, '0, 0, 0);
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, W'(i), 0, 0, '0, 0, 0);
    step(1, 16'hBEEF, 1, 0, '0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0, '0, 0, 0);
    do_reset();
    step(1, 16'h5555, 1, 0, '0, 0, 0);
    idle();
    do_reset();
    step(0, '0, 0, 1, 16'h1234, 0, 0);
    step(0, '0, 0, 0, '0, 1, 0);
    idle();
    for (int i = 0; i < 9; i++) step(0, '0, 0, 1, W'(16'hC000 + i), 0, 0);
    step(0, '0, 0, 1, 16'hDEAD, 1, 0);
    for (int i = 0; i < 9; i++) step(0, '0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, W'(i), 0, 1, W'(i + 100), 0, 0);
    step(1, 16'h7777, 0, 1, 16'h8888, 1, 1);
    idle();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 55, W'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 55, W'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 255) == 0);
    idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
